// File: rtl/bht_update_scheduler_pkg.sv
// Shared types and helpers for the PHT update scheduler: opcode constant, FSM states,
// queued update entry and the 2-bit saturating counter step.
package bht_update_scheduler_pkg;

   localparam int         PHT_IDX_W = 6;
   localparam logic [6:0] B_TYPE    = 7'b1100011;

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_e;

   typedef struct packed {
      logic [PHT_IDX_W-1:0] idx;
      logic [1:0]           ctr;
   } upd_t;

   function automatic logic [1:0] sat_update(input logic [1:0] old, input logic taken);
      if (taken) return (old == 2'b11) ? 2'b11 : old + 2'b01;
      else       return (old == 2'b00) ? 2'b00 : old - 2'b01;
   endfunction

endpackage

`ifndef B_type
`define B_type bht_update_scheduler_pkg::B_TYPE
`endif

// File: rtl/bht_upd_fifo.sv
// Update queue: FIFO storage with count/pointers, head output, and a parallel index
// compare over the live entries returning the youngest match for lookup forwarding.
module bht_upd_fifo
   import bht_update_scheduler_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push_vld_i,
   input  upd_t                 push_dat_i,
   input  logic                 pop_i,
   input  logic [PHT_IDX_W-1:0] cmp_idx_i,
   output upd_t                 head_dat_o,
   output logic                 full_o,
   output logic                 empty_o,
   output logic                 cmp_hit_o,
   output logic [1:0]           cmp_ctr_o
);

   upd_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, slot;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_vld_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)      rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_q + CNT_W'(push_vld_i) - CNT_W'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (push_vld_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign full_o     = (cnt_q == CNT_W'(DEPTH));
   assign empty_o    = (cnt_q == '0);

   // Walk oldest to youngest so the last hit left standing is the youngest entry.
   always_comb begin
      cmp_hit_o = 1'b0;
      cmp_ctr_o = 2'b00;
      slot      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         slot = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < cnt_q) && (mem_q[slot].idx == cmp_idx_i)) begin
            cmp_hit_o = 1'b1;
            cmp_ctr_o = mem_q[slot].ctr;
         end
      end
   end

endmodule

// File: rtl/bht_update_scheduler.sv
// Arbitrates a single-port PHT between IF lookups (1-cycle result) and queued EX updates;
// lookups win unless the queue is full, and an init sweep runs after every reset.
module bht_update_scheduler
   import bht_update_scheduler_pkg::*;
#(
   parameter int         IDX_W    = PHT_IDX_W,
   parameter int         Q_DEPTH  = 2,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             if_req,
   input  logic [31:0]      if_pc,
   output logic             if_ready,
   output logic             if_pred_valid,
   output logic [1:0]       if_pred_ctr,
   output logic             if_pred_taken,
   input  logic             ex_upd_valid,
   input  logic [6:0]       ex_op,
   input  logic [31:0]      ex_pc,
   input  logic [1:0]       ex_old_ctr,
   input  logic             ex_taken,
   output logic             ex_upd_ready,
   output logic             tbl_en,
   output logic             tbl_we,
   output logic [IDX_W-1:0] tbl_addr,
   output logic [1:0]       tbl_wdata,
   input  logic [1:0]       tbl_rdata,
   output logic             init_done
);

   localparam int ENTRIES = 2 ** IDX_W;

   state_e           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             sweep_go_q;
   logic             pred_vld_q, fwd_hit_q;
   logic [1:0]       fwd_ctr_q;

   upd_t             head_dat, push_dat;
   logic             q_full, q_empty, q_push, q_pop, cmp_hit, lookup;
   logic [1:0]       cmp_ctr;
   logic [IDX_W-1:0] lk_idx;
   logic             unused_pc_bits;

   assign lk_idx         = if_pc[IDX_W+1:2];
   assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0]};

   assign init_done    = (state_q == RUN);
   assign if_ready     = (state_q == RUN) && !q_full;
   assign ex_upd_ready = (state_q == RUN) && !q_full;
   assign q_push       = ex_upd_valid && (ex_op == `B_type) && ex_upd_ready;
   assign push_dat     = '{idx: ex_pc[IDX_W+1:2], ctr: sat_update(ex_old_ctr, ex_taken)};

   bht_upd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_vld_i (q_push),
      .push_dat_i (push_dat),
      .pop_i      (q_pop),
      .cmp_idx_i  (lk_idx),
      .head_dat_o (head_dat),
      .full_o     (q_full),
      .empty_o    (q_empty),
      .cmp_hit_o  (cmp_hit),
      .cmp_ctr_o  (cmp_ctr)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      tbl_en    = 1'b0;
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = 2'b00;
      lookup    = 1'b0;
      q_pop     = 1'b0;
      case (state_q)
         INIT: begin
            // sweep_go_q keeps the table quiet on the cycle right after a reset edge
            if (sweep_go_q) begin
               tbl_en    = 1'b1;
               tbl_we    = 1'b1;
               tbl_addr  = ptr_q;
               tbl_wdata = INIT_CTR;
               ptr_d     = ptr_q + IDX_W'(1);
               if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = RUN;
            end
         end
         RUN: begin
            if (if_req && !q_full) begin
               lookup   = 1'b1;
               tbl_en   = 1'b1;
               tbl_addr = lk_idx;
            end else if (!q_empty) begin
               q_pop     = 1'b1;
               tbl_en    = 1'b1;
               tbl_we    = 1'b1;
               tbl_addr  = head_dat.idx;
               tbl_wdata = head_dat.ctr;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= INIT;
         ptr_q      <= '0;
         sweep_go_q <= 1'b0;
         pred_vld_q <= 1'b0;
         fwd_hit_q  <= 1'b0;
         fwd_ctr_q  <= 2'b00;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         sweep_go_q <= 1'b1;
         pred_vld_q <= lookup;
         fwd_hit_q  <= lookup && cmp_hit;
         fwd_ctr_q  <= cmp_ctr;
      end
   end

   assign if_pred_valid = pred_vld_q;
   assign if_pred_ctr   = !pred_vld_q ? 2'b00 : (fwd_hit_q ? fwd_ctr_q : tbl_rdata);
   assign if_pred_taken = if_pred_ctr[1];

endmodule

// File: doc/bht_update_scheduler.md
Name: bht_update_scheduler

Overview:
- Controller that shares a single-port 2-bit-counter pattern history table (PHT) between two requesters: IF-stage prediction lookups and EX-stage branch-outcome updates.
- Holds a small update queue with saturating-counter arithmetic and lookup forwarding.
- Runs a post-reset initialisation sweep over every table entry.
- Sits between the fetch/execute pipeline stages and the PHT storage array.

Parameters:
- IDX_W, 6, PHT index width; table holds 2**IDX_W entries; index = pc[IDX_W+1:2].
- Q_DEPTH, 2, update queue entries (power of two, >= 2).
- INIT_CTR, 2'b01, counter value written to every entry during the init sweep (weakly not-taken).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- if_req  in  1  lookup request.
- if_pc  in  32  fetch PC for lookup.
- if_ready  out  1  lookup accepted this cycle when if_req && if_ready.
- if_pred_valid  out  1  prediction result valid.
- if_pred_ctr  out  2  counter value for accepted lookup.
- if_pred_taken  out  1  equals if_pred_ctr[1].
- ex_upd_valid  in  1  EX stage has a resolved instruction.
- ex_op  in  7  EX opcode; only `B_type is enqueued.
- ex_pc  in  32  branch PC.
- ex_old_ctr  in  2  counter value carried from prediction time.
- ex_taken  in  1  actual branch outcome.
- ex_upd_ready  out  1  queue can accept.
- tbl_en  out  1  table access strobe.
- tbl_we  out  1  table write enable.
- tbl_addr  out  IDX_W  table address.
- tbl_wdata  out  2  table write data.
- tbl_rdata  in  2  table read data, valid the cycle after a read strobe.
- init_done  out  1  init sweep complete.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to INIT, sweep pointer goes to 0, queue empties.
  - if_pred_valid=0, init_done=0, if_ready=0, ex_upd_ready=0.
  - tbl_en=0, tbl_we=0, tbl_addr=0, tbl_wdata=0.
  - Reset asserted at any point, including mid-sweep or with a non-empty queue, discards all state and restarts INIT.
- INIT:
  - Each cycle writes INIT_CTR to tbl_addr=pointer and increments the pointer.
  - After writing entry 2**IDX_W-1, the next cycle enters RUN with init_done=1.
  - The sweep takes exactly 2**IDX_W cycles.
  - if_ready and ex_upd_ready stay 0 throughout.
- RUN, per-cycle single-port arbitration:
  - Lookup priority: if the queue is not full and if_req=1, issue a read at if_pc index.
  - Drain: otherwise, if the queue is non-empty, write the head entry and pop it.
  - Full queue: when the queue is full, the write wins and if_ready=0 for that cycle, so lookups can never starve updates indefinitely.
  - if_ready = RUN && !queue_full.
  - ex_upd_ready = RUN && count<Q_DEPTH, evaluated on count at the start of the cycle.
- Enqueue:
  - Condition: ex_upd_valid && ex_op==`B_type && ex_upd_ready.
  - Non-branch opcodes are ignored entirely: no enqueue, no table effect.
  - Stored entry: idx, new_ctr.
  - new_ctr = ex_taken ? (old==2'b11 ? 2'b11 : old+1) : (old==2'b00 ? 2'b00 : old-1).
  - Simultaneous enqueue and dequeue in one cycle is allowed; count is unchanged.
  - An update is written to the table no earlier than the cycle after it is enqueued.
- Lookup result:
  - if_pred_valid=1 exactly one cycle after an accepted lookup, otherwise 0.
  - Forwarding: at acceptance, compare the lookup index against all queue entries present at the start of that cycle. On a match, register the youngest matching new_ctr and drive it instead of tbl_rdata.
  - An entry enqueued in the same cycle as the lookup is not forwarded.
- Queue order: FIFO; write pointer and read pointer wrap modulo Q_DEPTH.

Decomposition:
- Shared package holds:
  - B_TYPE opcode constant, aliased to `B_type.
  - State enum {INIT, RUN}.
  - Update-entry struct {idx, ctr}.
  - Saturating-counter update function.
- Natural sub-module: bht_upd_fifo, which holds storage, count, pointers, the head output, and a parallel compare port for forwarding.

Test Plan:
- Reset/init: hold rst=0 for 2 cycles, then release. Required: tbl writes addr 0..63 with 2'b01 on consecutive cycles, init_done rises on cycle 65, if_ready=0 until then. Re-asserting rst at sweep addr 20 restarts the sweep at addr 0.
- Lookup latency: if_req with if_pc=32'h0000_0010 and tbl_rdata=2'b10. Required: read at addr 4, then next cycle if_pred_valid=1, if_pred_ctr=2'b10, if_pred_taken=1.
- Saturation: B-type updates with (old 11, taken) / (old 00, not taken) / (old 01, taken). Required: tbl_wdata 11 / 00 / 10 respectively.
- Filter: ex_upd_valid=1 with ex_op=7'b0110011. Required: no enqueue, no tbl_we, count unchanged.
- Contention: if_req held at 1 while two updates are enqueued. Required: queue fills, next cycle if_ready=0 and the head is written, following cycle if_ready=1.
- Forwarding: enqueue pc=0x10, old 01, taken; then lookup pc=0x10 while if_req keeps the queue undrained and tbl_rdata=2'b01. Required: if_pred_ctr=2'b10.
